// File: rtl/valid_ctrl_pkg.sv
// Shared definitions for the valid-array controller: FSM states and set-count helper.
package valid_ctrl_pkg;

   typedef enum logic [1:0] {
      VC_IDLE,
      VC_UP_WR,
      VC_FLUSH
   } vc_state_t;

   function automatic int num_sets(input int s_index);
      return 1 << s_index;
   endfunction

endpackage

// File: rtl/valid_ctrl.sv
// Sequencer/arbiter that shares one valid_array between lookup, per-way update
// (read-modify-write) and a full-array flush sweep.
module valid_ctrl
   import valid_ctrl_pkg::*;
#(
   parameter int S_INDEX = 4,
   parameter int WIDTH   = 4
) (
   input  logic               clk0,
   input  logic               rst0,
   input  logic               lk_req,
   input  logic [S_INDEX-1:0] lk_set,
   output logic               lk_ready,
   output logic               lk_rvalid,
   output logic [WIDTH-1:0]   lk_rdata,
   input  logic               up_req,
   input  logic [S_INDEX-1:0] up_set,
   input  logic [WIDTH-1:0]   up_mask,
   input  logic               up_val,
   output logic               up_ready,
   output logic               up_done,
   input  logic               flush_req,
   output logic               flush_busy,
   output logic               flush_done,
   output logic               va_csb0,
   output logic               va_web0,
   output logic [S_INDEX-1:0] va_addr0,
   output logic [WIDTH-1:0]   va_din0,
   input  logic [WIDTH-1:0]   va_dout0
);

   localparam int               NUM_SETS = num_sets(S_INDEX);
   localparam logic [S_INDEX:0] CNT_LAST = (S_INDEX+1)'(NUM_SETS - 1);

   vc_state_t          state_reg, state_next;
   logic [S_INDEX:0]   cnt_reg, cnt_next;
   logic [S_INDEX-1:0] set_reg, set_next;
   logic [WIDTH-1:0]   mask_reg, mask_next;
   logic               val_reg, val_next;
   logic [S_INDEX-1:0] last_addr_reg;
   logic               lk_rvalid_reg, lk_rvalid_next;
   logic               flush_done_reg, flush_done_next;

   logic               web_c;
   logic [S_INDEX-1:0] addr_c;
   logic [WIDTH-1:0]   din_c;

   always_ff @(posedge clk0) begin
      if (rst0) begin
         state_reg      <= VC_IDLE;
         cnt_reg        <= '0;
         set_reg        <= '0;
         mask_reg       <= '0;
         val_reg        <= 1'b0;
         last_addr_reg  <= '0;
         lk_rvalid_reg  <= 1'b0;
         flush_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         set_reg        <= set_next;
         mask_reg       <= mask_next;
         val_reg        <= val_next;
         last_addr_reg  <= addr_c;
         lk_rvalid_reg  <= lk_rvalid_next;
         flush_done_reg <= flush_done_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      cnt_next        = cnt_reg;
      set_next        = set_reg;
      mask_next       = mask_reg;
      val_next        = val_reg;
      lk_rvalid_next  = 1'b0;
      flush_done_next = 1'b0;
      // Idle cycles re-read the previous address so write-enable never lingers.
      web_c           = 1'b1;
      addr_c          = last_addr_reg;
      din_c           = '0;
      up_ready        = 1'b0;
      lk_ready        = 1'b0;
      up_done         = 1'b0;
      flush_busy      = 1'b0;

      case (state_reg)
         VC_IDLE: begin
            up_ready = ~flush_req;
            lk_ready = ~flush_req & ~up_req;
            if (flush_req) begin
               state_next = VC_FLUSH;
               cnt_next   = '0;
            end else if (up_req) begin
               addr_c     = up_set;
               set_next   = up_set;
               mask_next  = up_mask;
               val_next   = up_val;
               state_next = VC_UP_WR;
            end else if (lk_req) begin
               addr_c         = lk_set;
               lk_rvalid_next = 1'b1;
            end
         end
         VC_UP_WR: begin
            // va_dout0 holds the read issued in the accepting IDLE cycle.
            web_c      = 1'b0;
            addr_c     = set_reg;
            din_c      = (va_dout0 & ~mask_reg) | (mask_reg & {WIDTH{val_reg}});
            up_done    = 1'b1;
            state_next = VC_IDLE;
         end
         VC_FLUSH: begin
            flush_busy = 1'b1;
            web_c      = 1'b0;
            addr_c     = cnt_reg[S_INDEX-1:0];
            cnt_next   = cnt_reg + 1'b1;
            if (cnt_reg == CNT_LAST) begin
               state_next      = VC_IDLE;
               flush_done_next = 1'b1;
            end
         end
         default: state_next = VC_IDLE;
      endcase
   end

   assign va_csb0    = 1'b0;
   assign va_web0    = web_c;
   assign va_addr0   = addr_c;
   assign va_din0    = din_c;
   assign lk_rvalid  = lk_rvalid_reg;
   assign lk_rdata   = lk_rvalid_reg ? va_dout0 : '0;
   assign flush_done = flush_done_reg;

endmodule

// File: tb/tb_valid_ctrl.sv
// Bench for valid_ctrl: array model, set-level reference model, directed and random traffic.
module tb_valid_ctrl;

   localparam int S  = 4;
   localparam int W  = 4;
   localparam int NS = 16;

   logic         clk0 = 1'b0;
   logic         rst0 = 1'b1;
   logic         lk_req = 1'b0, up_req = 1'b0, up_val = 1'b0, flush_req = 1'b0;
   logic [S-1:0] lk_set = '0, up_set = '0;
   logic [W-1:0] up_mask = '0;
   logic         lk_ready, lk_rvalid, up_ready, up_done, flush_busy, flush_done;
   logic [W-1:0] lk_rdata;
   logic         va_csb0, va_web0;
   logic [S-1:0] va_addr0;
   logic [W-1:0] va_din0, va_dout0;

   always #5 clk0 = ~clk0;

   valid_ctrl #(.S_INDEX(S), .WIDTH(W)) dut (
      .clk0(clk0), .rst0(rst0),
      .lk_req(lk_req), .lk_set(lk_set), .lk_ready(lk_ready),
      .lk_rvalid(lk_rvalid), .lk_rdata(lk_rdata),
      .up_req(up_req), .up_set(up_set), .up_mask(up_mask), .up_val(up_val),
      .up_ready(up_ready), .up_done(up_done),
      .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
      .va_csb0(va_csb0), .va_web0(va_web0), .va_addr0(va_addr0),
      .va_din0(va_din0), .va_dout0(va_dout0)
   );

   // Array: inputs registered on edge, read data next cycle, write commits one edge later.
   logic [W-1:0] mem [NS] = '{default: '0};
   logic         pend_we = 1'b0;
   logic [S-1:0] pend_a  = '0;
   logic [W-1:0] pend_d  = '0;
   logic [W-1:0] dout_r  = '0;
   assign va_dout0 = dout_r;

   always @(posedge clk0) begin
      if (pend_we) mem[pend_a] <= pend_d;
      pend_we <= 1'b0;
      if (!va_csb0) begin
         if (!va_web0) begin
            pend_we <= 1'b1;
            pend_a  <= va_addr0;
            pend_d  <= va_din0;
         end else begin
            dout_r <= (pend_we && pend_a == va_addr0) ? pend_d : mem[va_addr0];
         end
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: set contents plus outstanding-work counters.
   logic [W-1:0] ref_mem [NS] = '{default: '0};
   int           flush_left = 0;
   bit           up_wr = 0, lk_pend = 0, fdone_pend = 0;
   logic [W-1:0] lk_data = '0;
   int           lk_set_q = 0;
   bit           acc_lk = 0, acc_up = 0, acc_fl = 0;
   int           busy_seen = 0;

   task automatic tick();
      bit           idle, e_upr, e_lkr;
      logic [W-1:0] setbits;
      @(negedge clk0);
      idle  = (flush_left == 0) && !up_wr;
      e_upr = idle && !flush_req;
      e_lkr = e_upr && !up_req;
      check_val("up_ready", up_ready, e_upr);
      check_val("lk_ready", lk_ready, e_lkr);
      check_val("flush_busy", flush_busy, flush_left > 0);
      check_val("up_done", up_done, up_wr);
      check_val("flush_done", flush_done, fdone_pend);
      check_val("lk_rvalid", lk_rvalid, lk_pend);
      check_val("lk_rdata", lk_rdata, lk_pend ? lk_data : '0);
      check_val("va_csb0", va_csb0, 0);
      if (flush_busy === 1'b1) busy_seen++;
      if (lk_pend)    $display("t=%0t lookup set=%0d data=%b", $time, lk_set_q, lk_rdata);
      if (up_wr)      $display("t=%0t update write issued", $time);
      if (fdone_pend) $display("t=%0t flush complete", $time);

      if (flush_left > 0) ref_mem[NS - flush_left] = '0;
      acc_fl = idle && flush_req && !rst0;
      acc_up = e_upr && up_req && !rst0;
      acc_lk = e_lkr && lk_req && !rst0;
      if (acc_up) begin
         setbits = up_val ? up_mask : '0;
         ref_mem[up_set] = (ref_mem[up_set] & ~up_mask) | setbits;
      end
      if (rst0) begin
         flush_left = 0; up_wr = 0; lk_pend = 0; fdone_pend = 0;
      end else begin
         fdone_pend = (flush_left == 1);
         lk_pend    = acc_lk;
         lk_data    = ref_mem[lk_set];
         lk_set_q   = int'(lk_set);
         up_wr      = acc_up;
         flush_left = (flush_left > 0) ? flush_left - 1 : (acc_fl ? NS : 0);
      end
      @(posedge clk0);
      #1;
   endtask

   task automatic serve(input int bound);
      int n = 0;
      while ((lk_req || up_req || flush_req) && n < bound) begin
         tick();
         if (acc_lk) lk_req = 1'b0;
         if (acc_up) up_req = 1'b0;
         if (acc_fl) flush_req = 1'b0;
         n++;
      end
      check_val("serve_pending", {29'd0, lk_req, up_req, flush_req}, 0);
   endtask

   task automatic lookup(input int s);
      lk_req = 1'b1; lk_set = S'(s);
      serve(40);
   endtask

   task automatic update(input int s, input logic [W-1:0] m, input logic v);
      up_req = 1'b1; up_set = S'(s); up_mask = m; up_val = v;
      serve(40);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_reset_outs();
      check_val("rst_web", va_web0, 1);
      check_val("rst_addr", va_addr0, 0);
      check_val("rst_din", va_din0, 0);
      check_val("rst_rvalid", lk_rvalid, 0);
      check_val("rst_up_done", up_done, 0);
      check_val("rst_busy", flush_busy, 0);
      check_val("rst_fdone", flush_done, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (3) tick();
      rst0 = 1'b0;
      check_reset_outs();

      lookup(3);
      idle_cycles(2);

      update(5, 4'b0010, 1'b1);
      update(5, 4'b1000, 1'b1);
      lookup(5);
      idle_cycles(2);
      check_val("set5_ref", ref_mem[5], 4'b1010);

      update(5, 4'b0010, 1'b0);
      lookup(5);
      lookup(4);
      idle_cycles(2);

      update(0, 4'b1111, 1'b1);
      update(7, 4'b0101, 1'b1);
      update(15, 4'b1001, 1'b1);
      busy_seen = 0;
      flush_req = 1'b1;
      serve(40);
      idle_cycles(NS + 2);
      check_val("flush_busy_cycles", busy_seen, NS);
      lookup(0);
      lookup(7);
      lookup(15);
      idle_cycles(2);

      flush_req = 1'b1;
      up_req = 1'b1; up_set = 4'd2; up_mask = 4'b0100; up_val = 1'b1;
      lk_req = 1'b1; lk_set = 4'd2;
      serve(60);
      idle_cycles(2);

      update(12, 4'b0011, 1'b1);
      flush_req = 1'b1;
      serve(40);
      idle_cycles(5);
      rst0 = 1'b1;
      tick();
      rst0 = 1'b0;
      check_reset_outs();
      idle_cycles(NS + 2);
      lookup(2);
      lookup(12);
      idle_cycles(2);

      for (int c = 0; c < 500; c++) begin
         if (!lk_req && $urandom_range(0, 2) == 0) begin
            lk_req = 1'b1; lk_set = S'($urandom_range(0, NS - 1));
         end
         if (!up_req && $urandom_range(0, 3) == 0) begin
            up_req  = 1'b1;
            up_set  = S'($urandom_range(0, NS - 1));
            up_mask = W'($urandom_range(0, 15));
            up_val  = 1'($urandom_range(0, 1));
         end
         if (!flush_req && $urandom_range(0, 59) == 0) flush_req = 1'b1;
         tick();
         if (acc_lk) lk_req = 1'b0;
         if (acc_up) up_req = 1'b0;
         if (acc_fl) flush_req = 1'b0;
      end
      serve(100);
      idle_cycles(3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
